dual_issue_scoreboard: RTL and testbench
========================================

Name: dual_issue_scoreboard

Overview:
- Issue-control block in front of the SPU register-file/forwarding stage.
- Tracks in-flight destination writes for all 128 registers with per-register countdowns.
- Decides each cycle whether the even pipe, the odd pipe, both or neither may issue to the register-file read stage.
- Enforces in-order dual issue: odd never issues ahead of even. Handles RAW, WAW and intra-pair dependencies by stalling or splitting the pair.

Parameters:
NUM_REGS, 128, number of architectural registers
ADDR_W, 7, register address width
LAT_W, 3, width of write-back latency field
FWD_WINDOW, 1, countdown value at or below which a pending result is available by write-back forwarding (no stall)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
pair_valid  in  1  decoder presents an instruction pair
pair_ready  out  1  pair fully issued this cycle; decoder advances
instruction_even  in  32  even instruction; ra=[18:24], rb=[11:17], rc=[25:31]
instruction_odd  in  32  odd instruction; ra=[18:24], rb=[11:17], rt_st=[25:31]
src_used_even  in  3  {rc,ra,rb} read-enables for the even instruction
src_used_odd  in  3  {rt_st,ra,rb} read-enables for the odd instruction
rt_write_even  in  1  even instruction writes a register
rt_write_odd  in  1  odd instruction writes a register
rt_address_even  in  ADDR_W  even destination
rt_address_odd  in  ADDR_W  odd destination
rt_latency_even  in  LAT_W  cycles from issue to write-back (0 treated as 1)
rt_latency_odd  in  LAT_W  same, odd pipe
flush  in  1  discard the unissued remainder of the current pair
issue_even  out  1  even instruction issues this cycle
issue_odd  out  1  odd instruction issues this cycle
busy_count  out  8  registered count of registers with a nonzero countdown
stall_cycles  out  32  saturating count of cycles with pair_valid=1 and no issue

Behaviour:
- Reset (reset=0 at posedge):
  - all countdowns = 0, state = PAIR
  - busy_count = 0, stall_cycles = 0
  - issue_even, issue_odd and pair_ready are 0 while reset is low.
- hazard(src) = source enabled AND cnt[src] > FWD_WINDOW.
- waw(rt, L) = write enabled AND cnt[rt] > L.
- issue_even, issue_odd and pair_ready are combinational (Mealy) from state, inputs and current countdowns. A hazard-free pair issues in the same cycle it is presented.
- FSM state PAIR, with pair_valid=1 and flush=0:
  - even_ok = no even hazard AND no even waw.
  - odd_ok = no odd hazard AND no odd waw AND no intra-pair conflict. Intra-pair conflict: rt_write_even AND (an enabled odd source == rt_address_even, OR rt_write_odd with rt_address_odd == rt_address_even).
  - even_ok and odd_ok: issue both, pair_ready=1, stay in PAIR.
  - even_ok only: issue_even=1, go to ODD_ONLY.
  - even not ok: no issue, stay in PAIR. The odd instruction never issues alone from PAIR.
- FSM state ODD_ONLY:
  - odd_ok is evaluated with the intra-pair term dropped; the even result is now in the scoreboard.
  - odd_ok: issue_odd=1, pair_ready=1, go to PAIR.
  - otherwise hold in ODD_ONLY.
- pair_valid=0 in PAIR: no issue, no stall count.
- flush=1: no issue that cycle, pair_ready=1, state to PAIR.
  - Countdowns keep decrementing; in-flight writes still retire.
  - Flush has priority over issue.
- Countdown update at each posedge:
  - Every nonzero cnt decrements by 1.
  - An issued write then sets cnt[rt] = max(L,1), overriding the decrement.
  - Even and odd writes to the same rt in one cycle cannot occur (blocked by the intra-pair rule).
- busy_count reflects the post-update countdown array, one cycle after the update.
- stall_cycles saturates at 2^32-1.
- Register 127 and register 0 are ordinary; there is no hardwired register.

Decomposition:
- Package spu_sched_pkg:
  - state enum {PAIR, ODD_ONLY}
  - field slice constants for the ra, rb and rc/rt_st positions
  - latency typedef (LAT_W bits)
  - FWD_WINDOW default
- One sub-module, scoreboard_counter_array:
  - NUM_REGS countdowns
  - 6 read query ports plus 2 destination query ports
  - 2 set ports, global decrement, busy popcount
- The top level holds the FSM, hazard and conflict logic, and the stall counter.

Test Plan:
- Reset low 2 cycles, then pair with no sources or writes -> issue_even=issue_odd=pair_ready=1 in the same cycle; busy_count=0.
- Even writes r5 with L=4 (both issue); next pair's even reads r5 -> stalls 2 cycles (cnt 3, then 2), issues when cnt=1; stall_cycles=2.
- Pair with even writing r9 and odd reading r9 as ra, L=1 -> cycle 0 issue_even only (state ODD_ONLY); cycle 1 issue_odd=1, pair_ready=1.
- cnt[r3]=5 pending; even writes r3 with L=2 -> WAW stall until cnt[r3]<=2, then issue.
- ODD_ONLY held by an odd hazard, flush asserted -> no issue, pair_ready=1, state PAIR; cnt values keep decrementing.
- Reset low mid-stall with busy_count=4 -> next cycle all outputs 0, busy_count=0, and a fresh hazard-free pair issues immediately.

Source files
------------

// File: rtl/spu_sched_pkg.sv
// Shared types and constants for the SPU dual-issue scheduler: FSM states,
// instruction field positions, latency type and forwarding window.
package spu_sched_pkg;

    localparam int NUM_REGS  = 128;
    localparam int ADDR_W    = 7;
    localparam int LAT_W     = 3;
    localparam int NUM_QUERY = 8;
    localparam int NUM_SET   = 2;

    // Fields are given in big-endian bit numbering (bit 0 = MSB), so ra=[18:24] is [13:7] here
    localparam int RA_HI = 13;
    localparam int RA_LO = 7;
    localparam int RB_HI = 20;
    localparam int RB_LO = 14;
    localparam int RC_HI = 6;
    localparam int RC_LO = 0;

    typedef logic [LAT_W-1:0]  lat_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam lat_t FWD_WINDOW = 3'd1;
    localparam lat_t LAT_ONE    = 3'd1;

    typedef enum logic [0:0] {
        PAIR     = 1'b0,
        ODD_ONLY = 1'b1
    } sched_state_e;

    function automatic lat_t eff_latency(input lat_t lat);
        return (lat == 3'd0) ? LAT_ONE : lat;
    endfunction

endpackage

// File: rtl/dual_issue_scoreboard_if.sv
// Decoder-to-scheduler handshake: the presented instruction pair, its
// register usage and the per-pipe issue decisions.
interface dual_issue_scoreboard_if;
    import spu_sched_pkg::*;

    logic        pair_valid;
    logic        pair_ready;
    logic [31:0] instruction_even;
    logic [31:0] instruction_odd;
    logic [2:0]  src_used_even;
    logic [2:0]  src_used_odd;
    logic        rt_write_even;
    logic        rt_write_odd;
    reg_addr_t   rt_address_even;
    reg_addr_t   rt_address_odd;
    lat_t        rt_latency_even;
    lat_t        rt_latency_odd;
    logic        flush;
    logic        issue_even;
    logic        issue_odd;

    modport master (
        output pair_valid, instruction_even, instruction_odd, src_used_even, src_used_odd,
               rt_write_even, rt_write_odd, rt_address_even, rt_address_odd,
               rt_latency_even, rt_latency_odd, flush,
        input  pair_ready, issue_even, issue_odd
    );

    modport slave (
        input  pair_valid, instruction_even, instruction_odd, src_used_even, src_used_odd,
               rt_write_even, rt_write_odd, rt_address_even, rt_address_odd,
               rt_latency_even, rt_latency_odd, flush,
        output pair_ready, issue_even, issue_odd
    );

endinterface

// File: rtl/scoreboard_counter_array.sv
// Per-register write-back countdowns with lookup ports, issue-time set ports
// and a registered count of busy registers.
module scoreboard_counter_array
    import spu_sched_pkg::*;
(
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_QUERY-1:0][ADDR_W-1:0]      query_addr,
    output logic [NUM_QUERY-1:0][LAT_W-1:0]       query_cnt,
    input  logic [NUM_SET-1:0]                    set_en,
    input  logic [NUM_SET-1:0][ADDR_W-1:0]        set_addr,
    input  logic [NUM_SET-1:0][LAT_W-1:0]         set_val,
    output logic [7:0]                            busy_count
);

    lat_t       cnt_q [NUM_REGS];
    lat_t       cnt_d [NUM_REGS];
    logic [7:0] busy_q;
    logic [7:0] busy_d;

    // Decrement every live countdown, then let an issuing write override it
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = (cnt_q[i] != 3'd0) ? (cnt_q[i] - LAT_ONE) : cnt_q[i];
            for (int s = 0; s < NUM_SET; s++) begin
                cnt_d[i] = (set_en[s] && (set_addr[s] == reg_addr_t'(i))) ? set_val[s] : cnt_d[i];
            end
        end
    end

    // Popcount of registers still awaiting write-back
    always_comb begin
        busy_d = 8'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_d = busy_d + ((cnt_q[i] != 3'd0) ? 8'd1 : 8'd0);
        end
    end

    // Lookup ports read the current countdowns
    always_comb begin
        for (int q = 0; q < NUM_QUERY; q++) begin
            query_cnt[q] = cnt_q[query_addr[q]];
        end
    end

    // Countdown and busy-count registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= 3'd0;
            end
            busy_q <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_count = busy_q;

endmodule

// File: rtl/dual_issue_scoreboard.sv
// In-order dual-issue control: decides per cycle which pipes may read the
// register file, splitting or stalling pairs on RAW/WAW/intra-pair hazards.
module dual_issue_scoreboard
    import spu_sched_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    dual_issue_scoreboard_if.slave   bus,
    output logic [7:0]               busy_count,
    output logic [31:0]              stall_cycles
);

    sched_state_e                       state_q, state_d;
    logic [31:0]                        stall_q, stall_d;
    logic [NUM_QUERY-1:0][ADDR_W-1:0]   q_addr;
    logic [NUM_QUERY-1:0][LAT_W-1:0]    q_cnt;
    logic [NUM_SET-1:0]                 set_en;
    logic [NUM_SET-1:0][ADDR_W-1:0]     set_addr;
    logic [NUM_SET-1:0][LAT_W-1:0]      set_val;
    lat_t                               lat_even, lat_odd;
    logic                               even_hz, odd_hz, even_waw, odd_waw, intra;
    logic                               even_ok, odd_ok;
    logic                               issue_even_s, issue_odd_s, pair_ready_s;

    // Query slots: 0-2 even {rc,ra,rb}, 3-5 odd {rt_st,ra,rb}, 6-7 destinations
    always_comb begin
        q_addr[0] = bus.instruction_even[RC_HI:RC_LO];
        q_addr[1] = bus.instruction_even[RA_HI:RA_LO];
        q_addr[2] = bus.instruction_even[RB_HI:RB_LO];
        q_addr[3] = bus.instruction_odd[RC_HI:RC_LO];
        q_addr[4] = bus.instruction_odd[RA_HI:RA_LO];
        q_addr[5] = bus.instruction_odd[RB_HI:RB_LO];
        q_addr[6] = bus.rt_address_even;
        q_addr[7] = bus.rt_address_odd;
    end

    // Hazard, WAW and intra-pair conflict terms
    always_comb begin
        lat_even = eff_latency(bus.rt_latency_even);
        lat_odd  = eff_latency(bus.rt_latency_odd);
        even_hz  = |(bus.src_used_even & {q_cnt[0] > FWD_WINDOW, q_cnt[1] > FWD_WINDOW, q_cnt[2] > FWD_WINDOW});
        odd_hz   = |(bus.src_used_odd  & {q_cnt[3] > FWD_WINDOW, q_cnt[4] > FWD_WINDOW, q_cnt[5] > FWD_WINDOW});
        even_waw = bus.rt_write_even && (q_cnt[6] > lat_even);
        odd_waw  = bus.rt_write_odd  && (q_cnt[7] > lat_odd);
        intra    = bus.rt_write_even &&
                   ((|(bus.src_used_odd & {q_addr[3] == bus.rt_address_even,
                                           q_addr[4] == bus.rt_address_even,
                                           q_addr[5] == bus.rt_address_even})) ||
                    (bus.rt_write_odd && (bus.rt_address_odd == bus.rt_address_even)));
        even_ok  = !even_hz && !even_waw;
        odd_ok   = !odd_hz && !odd_waw;
    end

    // Issue FSM: odd only ever issues with or after its even partner
    always_comb begin
        issue_even_s = 1'b0;
        issue_odd_s  = 1'b0;
        pair_ready_s = 1'b0;
        state_d      = state_q;
        if (!reset) begin
            state_d = PAIR;
        end else if (bus.flush) begin
            pair_ready_s = 1'b1;
            state_d      = PAIR;
        end else if (!bus.pair_valid) begin
            state_d = state_q;
        end else begin
            case (state_q)
                PAIR: begin
                    if (even_ok) begin
                        issue_even_s = 1'b1;
                        if (odd_ok && !intra) begin
                            issue_odd_s  = 1'b1;
                            pair_ready_s = 1'b1;
                        end else begin
                            state_d = ODD_ONLY;
                        end
                    end else begin
                        state_d = PAIR;
                    end
                end
                ODD_ONLY: begin
                    if (odd_ok) begin
                        issue_odd_s  = 1'b1;
                        pair_ready_s = 1'b1;
                        state_d      = PAIR;
                    end else begin
                        state_d = ODD_ONLY;
                    end
                end
                default: state_d = PAIR;
            endcase
        end
    end

    // Scoreboard set requests and saturating stall counter
    always_comb begin
        set_en[0]   = issue_even_s && bus.rt_write_even;
        set_en[1]   = issue_odd_s && bus.rt_write_odd;
        set_addr[0] = bus.rt_address_even;
        set_addr[1] = bus.rt_address_odd;
        set_val[0]  = lat_even;
        set_val[1]  = lat_odd;
        stall_d     = (bus.pair_valid && !issue_even_s && !issue_odd_s && (stall_q != 32'hFFFF_FFFF))
                      ? (stall_q + 32'd1) : stall_q;
    end

    // State and stall counter registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= PAIR;
            stall_q <= 32'd0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    scoreboard_counter_array u_cnt (
        .clock      (clock),
        .reset      (reset),
        .query_addr (q_addr),
        .query_cnt  (q_cnt),
        .set_en     (set_en),
        .set_addr   (set_addr),
        .set_val    (set_val),
        .busy_count (busy_count)
    );

    assign bus.issue_even = issue_even_s;
    assign bus.issue_odd  = issue_odd_s;
    assign bus.pair_ready = pair_ready_s;
    assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Directed bench for dual_issue_scoreboard: each task drives one scenario and
// compares {issue_even, issue_odd, pair_ready}, busy_count and stall_cycles.
module tb_dual_issue_scoreboard;
    import spu_sched_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  busy_count;
    logic [31:0] stall_cycles;
    int          errors = 0;
    int          checks = 0;

    dual_issue_scoreboard_if bif ();

    dual_issue_scoreboard dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bif),
        .busy_count   (busy_count),
        .stall_cycles (stall_cycles)
    );

    always #5 clock = ~clock;

    // Encode ra/rb/rc into an instruction word (rb [20:14], ra [13:7], rc [6:0])
    function automatic logic [31:0] mk(input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc);
        return {11'd0, rb, ra, rc};
    endfunction

    function automatic logic [2:0] iss();
        return {bif.issue_even, bif.issue_odd, bif.pair_ready};
    endfunction

    task automatic apply(input logic v, input logic fl, input logic [31:0] ie, input logic [31:0] io,
                         input logic [2:0] sue, input logic [2:0] suo, input logic we, input logic wo,
                         input logic [6:0] ae, input logic [6:0] ao, input logic [2:0] le, input logic [2:0] lo);
        bif.pair_valid       = v;
        bif.flush            = fl;
        bif.instruction_even = ie;
        bif.instruction_odd  = io;
        bif.src_used_even    = sue;
        bif.src_used_odd     = suo;
        bif.rt_write_even    = we;
        bif.rt_write_odd     = wo;
        bif.rt_address_even  = ae;
        bif.rt_address_odd   = ao;
        bif.rt_latency_even  = le;
        bif.rt_latency_odd   = lo;
    endtask

    task automatic drive(input logic v, input logic fl, input logic [31:0] ie, input logic [31:0] io,
                         input logic [2:0] sue, input logic [2:0] suo, input logic we, input logic wo,
                         input logic [6:0] ae, input logic [6:0] ao, input logic [2:0] le, input logic [2:0] lo);
        @(negedge clock);
        apply(v, fl, ie, io, sue, suo, we, wo, ae, ao, le, lo);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        apply(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        repeat (2) @(posedge clock);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b000) begin errors++; $display("FAIL reset_outputs: got %b expected %b", iss(), 3'b000); end
        checks++; if (busy_count !== 8'd0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", busy_count); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b111) begin errors++; $display("FAIL free_pair: got %b expected %b", iss(), 3'b111); end
        checks++; if (busy_count !== 8'd0) begin errors++; $display("FAIL free_pair_busy: got %0d expected 0", busy_count); end
    endtask

    task automatic test_raw();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0, 7'd5, 7'd0, 3'd4, 3'd0);
        checks++; if (iss() !== 3'b111) begin errors++; $display("FAIL raw_writer: got %b expected %b", iss(), 3'b111); end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        drive(1'b1, 1'b0, mk(7'd5, 7'd0, 7'd0), 32'd0, 3'b010, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b000) begin errors++; $display("FAIL raw_stall_cnt3: got %b expected %b", iss(), 3'b000); end
        checks++; if (busy_count !== 8'd1) begin errors++; $display("FAIL raw_busy: got %0d expected 1", busy_count); end
        drive(1'b1, 1'b0, mk(7'd5, 7'd0, 7'd0), 32'd0, 3'b010, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b000) begin errors++; $display("FAIL raw_stall_cnt2: got %b expected %b", iss(), 3'b000); end
        drive(1'b1, 1'b0, mk(7'd5, 7'd0, 7'd0), 32'd0, 3'b010, 3'd0, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b111) begin errors++; $display("FAIL raw_issue_cnt1: got %b expected %b", iss(), 3'b111); end
        checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL raw_stall_count: got %0d expected 2", stall_cycles); end
    endtask

    task automatic test_intra_pair();
        drive(1'b1, 1'b0, 32'd0, mk(7'd9, 7'd0, 7'd0), 3'd0, 3'b010, 1'b1, 1'b0, 7'd9, 7'd0, 3'd1, 3'd0);
        checks++; if (iss() !== 3'b100) begin errors++; $display("FAIL intra_split_even: got %b expected %b", iss(), 3'b100); end
        drive(1'b1, 1'b0, 32'd0, mk(7'd9, 7'd0, 7'd0), 3'd0, 3'b010, 1'b1, 1'b0, 7'd9, 7'd0, 3'd1, 3'd0);
        checks++; if (iss() !== 3'b011) begin errors++; $display("FAIL intra_odd_follow: got %b expected %b", iss(), 3'b011); end
        checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL intra_no_stall: got %0d expected 2", stall_cycles); end
    endtask

    task automatic test_waw();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0, 7'd3, 7'd0, 3'd5, 3'd0);
        checks++; if (iss() !== 3'b111) begin errors++; $display("FAIL waw_first: got %b expected %b", iss(), 3'b111); end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0, 7'd3, 7'd0, 3'd2, 3'd0);
            checks++; if (iss() !== 3'b000) begin errors++; $display("FAIL waw_stall_%0d: got %b expected %b", k, iss(), 3'b000); end
        end
        drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0, 7'd3, 7'd0, 3'd2, 3'd0);
        checks++; if (iss() !== 3'b111) begin errors++; $display("FAIL waw_issue: got %b expected %b", iss(), 3'b111); end
        checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL waw_stall_count: got %0d expected 5", stall_cycles); end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0, 7'd20, 7'd0, 3'd6, 3'd0);
        checks++; if (iss() !== 3'b111) begin errors++; $display("FAIL flush_setup: got %b expected %b", iss(), 3'b111); end
        drive(1'b1, 1'b0, 32'd0, mk(7'd0, 7'd20, 7'd0), 3'd0, 3'b001, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b100) begin errors++; $display("FAIL flush_split: got %b expected %b", iss(), 3'b100); end
        drive(1'b1, 1'b0, 32'd0, mk(7'd0, 7'd20, 7'd0), 3'd0, 3'b001, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b000) begin errors++; $display("FAIL flush_odd_hold: got %b expected %b", iss(), 3'b000); end
        drive(1'b1, 1'b1, 32'd0, mk(7'd0, 7'd20, 7'd0), 3'd0, 3'b001, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b001) begin errors++; $display("FAIL flush_cycle: got %b expected %b", iss(), 3'b001); end
        drive(1'b1, 1'b0, 32'd0, mk(7'd0, 7'd20, 7'd0), 3'd0, 3'b001, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b100) begin errors++; $display("FAIL flush_back_in_pair: got %b expected %b", iss(), 3'b100); end
        drive(1'b1, 1'b0, 32'd0, mk(7'd0, 7'd20, 7'd0), 3'd0, 3'b001, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b000) begin errors++; $display("FAIL flush_cnt2_hold: got %b expected %b", iss(), 3'b000); end
        drive(1'b1, 1'b0, 32'd0, mk(7'd0, 7'd20, 7'd0), 3'd0, 3'b001, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b011) begin errors++; $display("FAIL flush_cnt1_issue: got %b expected %b", iss(), 3'b011); end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b1, 7'd0, 7'd127, 3'd7, 3'd7);
        checks++; if (iss() !== 3'b111) begin errors++; $display("FAIL edge_regs_write: got %b expected %b", iss(), 3'b111); end
        drive(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b1, 7'd40, 7'd41, 3'd7, 3'd7);
        checks++; if (iss() !== 3'b111) begin errors++; $display("FAIL mid_regs_write: got %b expected %b", iss(), 3'b111); end
        drive(1'b1, 1'b0, mk(7'd0, 7'd0, 7'd0), mk(7'd0, 7'd0, 7'd127), 3'b010, 3'b100, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b000) begin errors++; $display("FAIL r0_stall: got %b expected %b", iss(), 3'b000); end
        checks++; if (busy_count !== 8'd2) begin errors++; $display("FAIL busy_two: got %0d expected 2", busy_count); end
        drive(1'b1, 1'b0, mk(7'd0, 7'd0, 7'd0), mk(7'd0, 7'd0, 7'd127), 3'b010, 3'b100, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b000) begin errors++; $display("FAIL r0_stall_again: got %b expected %b", iss(), 3'b000); end
        checks++; if (busy_count !== 8'd4) begin errors++; $display("FAIL busy_four: got %0d expected 4", busy_count); end
        reset = 1'b0;
        drive(1'b1, 1'b0, mk(7'd0, 7'd0, 7'd0), mk(7'd0, 7'd0, 7'd127), 3'b010, 3'b100, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        checks++; if (iss() !== 3'b000) begin errors++; $display("FAIL midreset_outputs: got %b expected %b", iss(), 3'b000); end
        checks++; if (busy_count !== 8'd0) begin errors++; $display("FAIL midreset_busy: got %0d expected 0", busy_count); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL midreset_stall: got %0d expected 0", stall_cycles); end
        @(negedge clock);
        reset = 1'b1;
        apply(1'b1, 1'b0, mk(7'd0, 7'd0, 7'd127), mk(7'd40, 7'd0, 7'd0), 3'b110, 3'b010, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0);
        #1;
        checks++; if (iss() !== 3'b111) begin errors++; $display("FAIL post_reset_issue: got %b expected %b", iss(), 3'b111); end
        checks++; if (busy_count !== 8'd0) begin errors++; $display("FAIL post_reset_busy: got %0d expected 0", busy_count); end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_raw();
        test_intra_pair();
        test_waw();
        test_flush();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
